// File: rtl/riscv_pkg.sv
// Shared encodings for the writeback stage: writeback source select, load funct3, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package riscv_pkg;

  // Writeback source select as decoded by the instruction decoder
  typedef enum logic [1:0] {
    WB_LOAD = 2'd0,
    WB_ALU  = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wbsel_e;

  // Load width / extension selects (RV32I funct3 for loads)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  // Cycles a load may wait for read data before it is abandoned
  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/riscv_load_align.sv
// Aligns a data-memory read word to the addressed byte/halfword and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module riscv_load_align
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            addr,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] byte_sh;
  logic [DATA_WIDTH-1:0] half_sh;

  // Byte lane selected by both address bits, halfword lane by addr[1] only
  assign byte_sh = rdata >> {addr, 3'b000};
  assign half_sh = rdata >> {addr[1], 4'b0000};

  // Pick extension by load type; anything unlisted behaves as a full word load
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
      F3_LH:   data = {{(DATA_WIDTH-16){half_sh[15]}}, half_sh[15:0]};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_wb_unit.sv
// Writeback unit: takes one instruction, optionally waits for load data, writes the register file.
// Latency: non-load start N -> rf_wen N+1; load dmem_rvalid M -> rf_wen M+1.
// Backpressure: busy while holding an instruction; starts arriving while busy are dropped.
module riscv_wb_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PC_WIDTH    = 15,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            wbsel,
  input  logic                  regwen,
  input  logic [4:0]            rd,
  input  logic [2:0]            funct3,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_rvalid,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy,
  output logic                  mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  wb_state_e             state;
  wb_state_e             state_nxt;
  logic [CNT_W-1:0]      wait_cnt;

  // Instruction fields held across the load wait
  logic [1:0]            wbsel_q;
  logic                  regwen_q;
  logic [4:0]            rd_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_q;

  logic                  accept;
  logic                  load_done;
  logic                  timeout;
  logic [PC_WIDTH:0]     pc4;
  logic [DATA_WIDTH-1:0] load_data;

  // Staged values for the registered write port, loaded on the edge entering WRITE
  logic                  wr_en_nxt;
  logic [4:0]            wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;

  assign accept    = (state == ST_IDLE) && start;
  assign load_done = (state == ST_WAIT_MEM) && dmem_rvalid;
  assign timeout   = (state == ST_WAIT_MEM) && !dmem_rvalid &&
                     (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  // One extra bit so PC+4 never wraps before zero-extension
  assign pc4       = {1'b0, pc} + (PC_WIDTH + 1)'(4);

  riscv_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata  (dmem_rdata),
    .addr   (addr_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (wbsel == WB_LOAD) ? ST_WAIT_MEM : ST_WRITE;
      end
      ST_WAIT_MEM: begin
        if (dmem_rvalid)  state_nxt = ST_WRITE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Build the write that will be presented during the coming WRITE cycle
  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = rf_waddr;
    wr_data_nxt = rf_wdata;
    if (accept && (wbsel != WB_LOAD)) begin
      wr_en_nxt   = regwen && (rd != 5'd0) && (wbsel != WB_NONE);
      wr_addr_nxt = rd;
      case (wbsel)
        WB_PC4:  wr_data_nxt = DATA_WIDTH'(pc4);
        default: wr_data_nxt = alu_out;
      endcase
    end else if (load_done) begin
      wr_en_nxt   = regwen_q && (rd_q != 5'd0) && (wbsel_q != WB_NONE);
      wr_addr_nxt = rd_q;
      wr_data_nxt = load_data;
    end
  end

  // Registered write port; reset wins over any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_wen   <= wr_en_nxt;
      rf_waddr <= wr_addr_nxt;
      rf_wdata <= wr_data_nxt;
    end
  end

  // Capture instruction fields only when a start is accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      wbsel_q  <= 2'd0;
      regwen_q <= 1'b0;
      rd_q     <= 5'd0;
      funct3_q <= 3'd0;
      addr_q   <= 2'd0;
    end else if (accept) begin
      wbsel_q  <= wbsel;
      regwen_q <= regwen;
      rd_q     <= rd;
      funct3_q <= funct3;
      addr_q   <= alu_out[1:0];
    end
  end

  // Load wait counter: zero on entry to WAIT_MEM, counts each cycle spent there
  always_ff @(posedge clk) begin
    if (rst || (state != ST_WAIT_MEM)) wait_cnt <= '0;
    else                               wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Sticky load-timeout flag, cleared by the next accepted instruction
  always_ff @(posedge clk) begin
    if (rst)          mem_err <= 1'b0;
    else if (accept)  mem_err <= 1'b0;
    else if (timeout) mem_err <= 1'b1;
  end

endmodule
